// File: rtl/pdp11_bus_pkg.sv
// Shared definitions for the PDP-11 bus switch: address map defaults,
// switch state encoding and the byte-lane replicate helper.
package pdp11_bus_pkg;

    localparam logic [21:0] RAM_TOP_DEF     = 22'o0760000;
    localparam logic [21:0] IOPAGE_BASE_DEF = 22'o17760000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAM  = 3'd1,
        ST_IO   = 3'd2,
        ST_ACK  = 3'd3,
        ST_DMA  = 3'd4
    } bus_state_t;

    // Byte writes present the same byte on both lanes; the target picks the lane.
    function automatic logic [15:0] byte_rep(input logic [7:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/pdp11_bus_decode.sv
// Combinational address decode of a 22-bit CPU address into RAM, I/O page
// or non-existent memory.
module pdp11_bus_decode
    import pdp11_bus_pkg::*;
#(
    parameter logic [21:0] RAM_TOP     = RAM_TOP_DEF,
    parameter logic [21:0] IOPAGE_BASE = IOPAGE_BASE_DEF
) (
    input  logic [21:0] addr,
    output logic        sel_ram,
    output logic        sel_io,
    output logic        sel_nxm
);

    always_comb begin
        sel_ram = (addr < RAM_TOP);
        sel_io  = !sel_ram && (addr >= IOPAGE_BASE);
        sel_nxm = !sel_ram && !sel_io;
    end

endmodule

// File: rtl/pdp11_bus_switch.sv
// Bus switch between CPU, RAM, the I/O page and one DMA master.
// Define BUS_DEBUG_EN to print each completed CPU and DMA cycle in simulation.
module pdp11_bus_switch
    import pdp11_bus_pkg::*;
#(
    parameter logic [21:0] RAM_TOP     = RAM_TOP_DEF,
    parameter logic [21:0] IOPAGE_BASE = IOPAGE_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side: bus_rd/bus_wr are levels held until bus_ack; bus_ack stays
    // high until both drop, and the switch returns to idle the next cycle.
    input  logic [21:0] bus_addr,
    input  logic [15:0] bus_data_in,
    output logic [15:0] bus_data_out,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic        bus_byte_op,
    input  logic        bus_arbitrate,
    output logic        bus_ack,
    output logic        bus_error,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        ram_byte_op,
    input  logic        ram_done,
    output logic [12:0] io_addr,
    output logic [15:0] io_data_out,
    input  logic [15:0] io_data_in,
    output logic        io_rd,
    output logic        io_wr,
    output logic        io_byte_op,
    input  logic        io_claim,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [21:0] dma_addr,
    input  logic [15:0] dma_data_in,
    input  logic        dma_rd,
    input  logic        dma_wr,
    output logic        dma_done,
    output bus_state_t  state_dbg
);

    bus_state_t  state, state_next;
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;
    logic        sel_ram, sel_io, sel_nxm;
    logic        cpu_req;
    logic [15:0] wdata;

    pdp11_bus_decode #(
        .RAM_TOP     (RAM_TOP),
        .IOPAGE_BASE (IOPAGE_BASE)
    ) u_decode (
        .addr    (bus_addr),
        .sel_ram (sel_ram),
        .sel_io  (sel_io),
        .sel_nxm (sel_nxm)
    );

    assign cpu_req = bus_rd || bus_wr;
    assign wdata   = bus_byte_op ? byte_rep(bus_data_in[7:0]) : bus_data_in;

    always_comb begin
        state_next   = state;
        data_d       = data_q;
        err_d        = err_q;
        ram_addr     = '0;
        ram_data_out = '0;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        ram_byte_op  = 1'b0;
        io_addr      = '0;
        io_data_out  = '0;
        io_rd        = 1'b0;
        io_wr        = 1'b0;
        io_byte_op   = 1'b0;
        dma_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                err_d = 1'b0;
                // DMA takes precedence over a simultaneous CPU request.
                if (dma_req && bus_arbitrate) begin
                    state_next = ST_DMA;
                end else if (cpu_req) begin
                    if (sel_ram) begin
                        state_next = ST_RAM;
                    end else if (sel_io) begin
                        state_next = ST_IO;
                    end else begin
                        state_next = ST_ACK;
                        err_d      = sel_nxm;
                    end
                end
            end
            ST_RAM: begin
                ram_addr     = bus_addr;
                ram_data_out = wdata;
                ram_rd       = bus_rd;
                ram_wr       = bus_wr;
                ram_byte_op  = bus_byte_op;
                if (ram_done) begin
                    data_d     = ram_data_in;
                    state_next = ST_ACK;
                end
            end
            ST_IO: begin
                io_addr     = bus_addr[12:0];
                io_data_out = wdata;
                io_rd       = bus_rd;
                io_wr       = bus_wr;
                io_byte_op  = bus_byte_op;
                if (io_claim) data_d = io_data_in;
                err_d      = !io_claim;
                state_next = ST_ACK;
            end
            ST_ACK: begin
                if (!cpu_req) state_next = ST_IDLE;
            end
            ST_DMA: begin
                ram_addr     = dma_addr;
                ram_data_out = dma_data_in;
                ram_rd       = dma_rd;
                ram_wr       = dma_wr;
                dma_done     = ram_done && (dma_rd || dma_wr);
                if (ram_done && dma_rd) data_d = ram_data_in;
                if (!dma_req) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign bus_ack      = (state == ST_ACK);
    assign bus_error    = bus_ack && err_q;
    assign bus_data_out = data_q;
    assign dma_gnt      = (state == ST_DMA);
    assign state_dbg    = state;

`ifdef BUS_DEBUG_EN
    always_ff @(posedge clk) begin
        if (!reset && state != ST_ACK && state_next == ST_ACK)
            $display("bus: cpu %s addr=%o data=%o err=%0d",
                     bus_wr ? "wr" : "rd", bus_addr, bus_wr ? wdata : data_d, err_d);
        if (!reset && dma_done)
            $display("bus: dma %s addr=%o data=%o err=0",
                     dma_wr ? "wr" : "rd", dma_addr, dma_wr ? dma_data_in : ram_data_in);
    end
`else
`endif

endmodule

// File: tb/tb_pdp11_bus_switch.sv
// Directed bench for pdp11_bus_switch with a behavioural RAM and I/O device.
module tb_pdp11_bus_switch;
    import pdp11_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [21:0] bus_addr;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_out;
    logic        bus_rd, bus_wr, bus_byte_op, bus_arbitrate;
    logic        bus_ack, bus_error;
    logic [21:0] ram_addr;
    logic [15:0] ram_data_out, ram_data_in;
    logic        ram_rd, ram_wr, ram_byte_op;
    logic        ram_done;
    logic [12:0] io_addr;
    logic [15:0] io_data_out, io_data_in;
    logic        io_rd, io_wr, io_byte_op, io_claim;
    logic        dma_req, dma_gnt;
    logic [21:0] dma_addr;
    logic [15:0] dma_data_in;
    logic        dma_rd, dma_wr, dma_done;
    bus_state_t  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    pdp11_bus_switch dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_byte_op(bus_byte_op),
        .bus_arbitrate(bus_arbitrate), .bus_ack(bus_ack), .bus_error(bus_error),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_byte_op(ram_byte_op), .ram_done(ram_done),
        .io_addr(io_addr), .io_data_out(io_data_out), .io_data_in(io_data_in),
        .io_rd(io_rd), .io_wr(io_wr), .io_byte_op(io_byte_op), .io_claim(io_claim),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_addr(dma_addr),
        .dma_data_in(dma_data_in), .dma_rd(dma_rd), .dma_wr(dma_wr),
        .dma_done(dma_done), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // RAM model: ram_done pulses ram_lat+1 cycles after strobes appear
    logic [15:0] mem [0:2047];
    int          ram_lat = 1;
    int          ram_cnt = 0;
    assign ram_data_in = mem[ram_addr[11:1]];

    always @(posedge clk) begin
        if (reset) begin
            ram_cnt  <= 0;
            ram_done <= 1'b0;
        end else begin
            ram_done <= 1'b0;
            if ((ram_rd || ram_wr) && !ram_done) begin
                if (ram_cnt >= ram_lat) begin
                    ram_done <= 1'b1;
                    ram_cnt  <= 0;
                    if (ram_wr) begin
                        if (ram_byte_op)
                            mem[ram_addr[11:1]][ram_addr[0]*8 +: 8] <= ram_data_out[7:0];
                        else
                            mem[ram_addr[11:1]] <= ram_data_out;
                    end
                end else begin
                    ram_cnt <= ram_cnt + 1;
                end
            end
        end
    end

    // I/O device and strobe monitors
    logic        io_claim_en = 1'b0;
    logic [15:0] io_rdata    = 16'hbeef;
    assign io_claim   = io_claim_en;
    assign io_data_in = io_rdata;

    int          io_wr_cnt = 0, ram_wr_cyc = 0, dma_done_cnt = 0, gnt_cyc = 0;
    logic [12:0] io_addr_cap = '0;
    logic [15:0] io_wdata_cap = '0, ram_wdata_cap = '0;
    logic        ram_bop_cap = 1'b0;

    always @(posedge clk) begin
        if (io_wr) begin
            io_wr_cnt    <= io_wr_cnt + 1;
            io_addr_cap  <= io_addr;
            io_wdata_cap <= io_data_out;
        end
        if (ram_wr) begin
            ram_wr_cyc    <= ram_wr_cyc + 1;
            ram_bop_cap   <= ram_byte_op;
            ram_wdata_cap <= ram_data_out;
        end
        if (dma_done) dma_done_cnt <= dma_done_cnt + 1;
        if (dma_gnt)  gnt_cyc      <= gnt_cyc + 1;
    end

    // scoreboard
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_cycle(input logic [21:0] a, input logic [15:0] d, input logic wr,
                             input logic bop, output logic [15:0] rdata, output logic err,
                             output int cyc);
        bit got;
        got   = 0;
        cyc   = 0;
        rdata = '0;
        err   = 1'b0;
        bus_addr    = a;
        bus_data_in = d;
        bus_byte_op = bop;
        bus_wr      = wr;
        bus_rd      = !wr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_ack) begin
                got   = 1;
                rdata = bus_data_out;
                err   = bus_error;
                break;
            end
            step();
            cyc++;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        step();
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_byte_op = 1'b0;
        step();
        step();
    endtask

    logic [15:0] rd;
    logic        er;
    int          cy, base;
    logic [21:0] wa [0:4];
    logic [15:0] wd [0:4];
    logic [15:0] pat;
    bit          seen;

    initial begin
        reset = 1'b1;
        bus_addr = '0; bus_data_in = '0; bus_rd = 0; bus_wr = 0; bus_byte_op = 0;
        bus_arbitrate = 0; dma_req = 0; dma_addr = '0; dma_data_in = '0;
        dma_rd = 0; dma_wr = 0;
        repeat (3) step();

        check("reset_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("reset_outs", {bus_ack, bus_error, ram_rd, ram_wr, io_rd, io_wr, dma_gnt, dma_done,
                             bus_data_out}, 32'd0);
        reset = 1'b0;
        step();

        // non-existent address
        base = ram_wr_cyc + io_wr_cnt;
        cpu_cycle(22'o0776000, 16'h1111, 1'b1, 1'b0, rd, er, cy);
        check("nxm_err", {31'd0, er}, 32'd1);
        check("nxm_no_strobe", ram_wr_cyc + io_wr_cnt - base, 32'd0);
        check("nxm_lat", cy, 32'd1);
        check("err_clears", {30'd0, bus_ack, bus_error}, 32'd0);

        // word writes then readback through the expected queue
        wa[0] = 22'o0;  wd[0] = 16'ha5a5;
        wa[1] = 22'o2;  wd[1] = 16'h5a5a;
        wa[2] = 22'o4;  wd[2] = 16'o1234;
        wa[3] = 22'o6;  wd[3] = 16'o177777;
        wa[4] = 22'o10; wd[4] = 16'o54321;
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(wa[i], wd[i], 1'b1, 1'b0, rd, er, cy);
            exp_q.push_back(wd[i]);
        end
        check("ram_lat", cy, 32'd4);
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(wa[i], 16'h0, 1'b0, 1'b0, rd, er, cy);
            check("ram_rd", rd, exp_q.pop_front());
            check("ram_rd_err", {31'd0, er}, 32'd0);
        end

        // I/O page write, claimed and unclaimed, and a claimed read
        io_claim_en = 1'b1;
        base = io_wr_cnt;
        cpu_cycle(22'o17777404, 16'd5, 1'b1, 1'b0, rd, er, cy);
        check("io_wr_pulses", io_wr_cnt - base, 32'd1);
        check("io_addr", {19'd0, io_addr_cap}, 32'h00001f04);
        check("io_wdata", io_wdata_cap, 32'd5);
        check("io_err", {31'd0, er}, 32'd0);
        check("io_lat", cy, 32'd2);
        cpu_cycle(22'o17777404, 16'd0, 1'b0, 1'b0, rd, er, cy);
        check("io_rdata", rd, 32'h0000beef);
        io_claim_en = 1'b0;
        cpu_cycle(22'o17777404, 16'd5, 1'b1, 1'b0, rd, er, cy);
        check("io_noclaim_err", {31'd0, er}, 32'd1);

        // byte write to the high byte of word 0
        cpu_cycle(22'o1, 16'h003c, 1'b1, 1'b1, rd, er, cy);
        check("byte_op", {31'd0, ram_bop_cap}, 32'd1);
        check("byte_rep", ram_wdata_cap, 32'h00003c3c);
        cpu_cycle(22'o0, 16'h0, 1'b0, 1'b0, rd, er, cy);
        check("byte_readback", rd, 32'h00003ca5);

        // DMA with arbitration disabled: no grant, CPU still served
        base = gnt_cyc;
        dma_req = 1'b1;
        cpu_cycle(22'o2, 16'h0, 1'b0, 1'b0, rd, er, cy);
        repeat (4) step();
        check("no_arb_gnt", gnt_cyc - base, 32'd0);
        check("no_arb_cpu", rd, 32'h00005a5a);
        dma_req = 1'b0;
        step();

        // DMA block write of 256 words at 0o1000
        bus_arbitrate = 1'b1;
        dma_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = dma_gnt;
        end
        check("dma_gnt", {31'd0, seen}, 32'd1);
        base = dma_done_cnt;
        for (int w = 0; w < 256; w++) begin
            pat = 16'h1357 + 16'(w) * 16'd3;
            dma_addr    = 22'o1000 + 22'(2 * w);
            dma_data_in = pat;
            dma_wr      = 1'b1;
            exp_q.push_back(pat);
            seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = dma_done;
                step();
            end
            if (!seen) check("dma_done_timeout", 32'd0, 32'd1);
            dma_wr = 1'b0;
        end
        check("dma_done_cnt", dma_done_cnt - base, 32'd256);
        check("dma_gnt_held", {31'd0, dma_gnt}, 32'd1);
        dma_req = 1'b0;
        step();
        step();
        check("dma_release", {31'd0, dma_gnt}, 32'd0);
        for (int w = 0; w < 256; w++) begin
            cpu_cycle(22'o1000 + 22'(2 * w), 16'h0, 1'b0, 1'b0, rd, er, cy);
            check("dma_readback", rd, exp_q.pop_front());
        end

        // simultaneous DMA and CPU request: DMA wins, CPU stalls
        bus_addr = 22'o4;
        bus_rd   = 1'b1;
        dma_req  = 1'b1;
        step();
        check("contend_state", {29'd0, state_dbg}, {29'd0, ST_DMA});
        repeat (3) step();
        check("contend_stall", {31'd0, bus_ack}, 32'd0);
        dma_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus_ack;
            if (!seen) step();
        end
        check("contend_ack", {31'd0, seen}, 32'd1);
        check("contend_data", bus_data_out, 32'o1234);
        step();
        bus_rd = 1'b0;
        bus_arbitrate = 1'b0;
        repeat (2) step();

        // reset in the middle of a RAM wait
        ram_lat  = 6;
        bus_addr = 22'o2;
        bus_rd   = 1'b1;
        repeat (3) step();
        check("pre_reset_ram", {28'd0, state_dbg, ram_rd}, {28'd0, ST_RAM, 1'b1});
        reset  = 1'b1;
        bus_rd = 1'b0;
        step();
        check("mid_reset_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        check("mid_reset_outs", {bus_ack, bus_error, ram_rd, ram_wr, io_rd, io_wr, dma_gnt,
                                 dma_done, bus_data_out}, 32'd0);
        reset   = 1'b0;
        ram_lat = 1;
        repeat (2) step();
        cpu_cycle(22'o2, 16'h0, 1'b0, 1'b0, rd, er, cy);
        check("post_reset_rd", rd, 32'h00005a5a);
        check("post_reset_err", {31'd0, er}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
